// File: rtl/rob_retire_queue.sv
`default_nettype none
// ============================================================================
// Module   : rob_retire_queue
// Purpose  : In-order reorder buffer holding each instruction's old destination
//            tag. Completions arrive on independent wakeup channels; up to
//            RETIRE_W completed entries retire per cycle from the head and
//            release their old tags to the rename free pool.
// Revision : 1.0  initial release
// ============================================================================
module rob_retire_queue #(
  parameter  int DEPTH    = 64,
  parameter  int TAG_W    = 6,
  parameter  int RETIRE_W = 2,
  parameter  int WAKE_CH  = 2,
  localparam int IDX_W    = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enq_valid_i,
  input  logic [TAG_W-1:0]          enq_old_tag_i,
  output logic                      enq_ready_o,
  output logic [IDX_W-1:0]          enq_index_o,
  input  logic [WAKE_CH-1:0]        wake_valid_i,
  input  logic [WAKE_CH*IDX_W-1:0]  wake_index_i,
  output logic [RETIRE_W-1:0]       freed_valid_o,
  output logic [RETIRE_W*TAG_W-1:0] freed_tag_o,
  output logic [IDX_W:0]            count_o,
  output logic                      error_o
);

  logic [TAG_W-1:0] tag_q [DEPTH];
  logic [DEPTH-1:0] done_q, done_d;
  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [IDX_W:0]   count_q, count_d;
  logic             error_q, error_d;

  logic             enq_fire;
  logic [IDX_W:0]   retire_cnt;
  logic [DEPTH-1:0] retire_mask;
  logic [DEPTH-1:0] wake_set;
  logic             wake_err;
  logic [IDX_W-1:0] ridx;
  logic [IDX_W-1:0] widx;
  logic [IDX_W-1:0] woff;
  logic             run;
  logic             wdup;

  // Space check uses registered count only, so retirement never feeds enq_ready.
  assign enq_ready_o = (count_q != (IDX_W+1)'(DEPTH));
  assign enq_fire    = enq_valid_i & enq_ready_o;
  assign enq_index_o = tail_q;
  assign count_o     = count_q;
  assign error_o     = error_q;

  // Retire lanes: contiguous run of done entries starting at head, stopping at the first hole.
  always_comb begin
    run           = 1'b1;
    retire_cnt    = '0;
    retire_mask   = '0;
    freed_valid_o = '0;
    freed_tag_o   = '0;
    ridx          = head_q;
    for (int k = 0; k < RETIRE_W; k++) begin
      ridx = head_q + IDX_W'(k);
      if (run && ((IDX_W+1)'(k) < count_q) && done_q[ridx]) begin
        freed_valid_o[k]                = 1'b1;
        freed_tag_o[k*TAG_W +: TAG_W]   = tag_q[ridx];
        retire_mask[ridx]               = 1'b1;
        retire_cnt                      = retire_cnt + 1'b1;
      end else begin
        run = 1'b0;
      end
    end
  end

  // Wakeup validation: slot must be live (wrap-aware offset from head), not yet done,
  // and not already claimed by a lower-numbered channel this cycle.
  always_comb begin
    wake_set = '0;
    wake_err = 1'b0;
    widx     = '0;
    woff     = '0;
    wdup     = 1'b0;
    for (int c = 0; c < WAKE_CH; c++) begin
      if (wake_valid_i[c]) begin
        widx = wake_index_i[c*IDX_W +: IDX_W];
        woff = widx - head_q;
        wdup = 1'b0;
        for (int j = 0; j < c; j++) begin
          if (wake_valid_i[j] && (wake_index_i[j*IDX_W +: IDX_W] == widx)) begin
            wdup = 1'b1;
          end
        end
        if (({1'b0, woff} < count_q) && !done_q[widx] && !wdup) begin
          wake_set[widx] = 1'b1;
        end else begin
          wake_err = 1'b1;
        end
      end
    end
  end

  // Next-state: retired slots clear, woken slots set, a fresh enqueue starts not-done.
  always_comb begin
    done_d = (done_q & ~retire_mask) | wake_set;
    if (enq_fire) begin
      done_d[tail_q] = 1'b0;
    end
    // Truncation to IDX_W bits is the intended modulo-DEPTH wrap.
    head_d  = head_q + retire_cnt[IDX_W-1:0];
    tail_d  = tail_q + IDX_W'(enq_fire);
    count_d = count_q - retire_cnt + (IDX_W+1)'(enq_fire);
    error_d = error_q | wake_err | (enq_valid_i & ~enq_ready_o);
  end

  // Control state with asynchronous reset so freed outputs drop immediately on rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      error_q <= 1'b0;
    end else begin
      done_q  <= done_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      error_q <= error_d;
    end
  end

  // Tag storage needs no reset: a tag is only observed once its slot is live and done.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      tag_q[tail_q] <= enq_old_tag_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rob_retire_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_rob_retire_queue
// Purpose  : Self-checking bench for rob_retire_queue (DEPTH=64, TAG_W=6,
//            RETIRE_W=2, WAKE_CH=2): directed vector table, hand sequences for
//            full/error/async-reset corners, and a randomized run against a
//            program-order queue model.
// Revision : 1.0  initial release
// ============================================================================
module tb_rob_retire_queue;

  localparam int D = 64;

  logic        clk;
  logic        rst;
  logic        enq_valid;
  logic [5:0]  enq_old_tag;
  logic        enq_ready;
  logic [5:0]  enq_index;
  logic [1:0]  wake_valid;
  logic [11:0] wake_index;
  logic [1:0]  freed_valid;
  logic [11:0] freed_tag;
  logic [6:0]  count;
  logic        error;

  int checks = 0;
  int errs   = 0;

  rob_retire_queue #(.DEPTH(64), .TAG_W(6), .RETIRE_W(2), .WAKE_CH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .enq_valid_i  (enq_valid),
    .enq_old_tag_i(enq_old_tag),
    .enq_ready_o  (enq_ready),
    .enq_index_o  (enq_index),
    .wake_valid_i (wake_valid),
    .wake_index_i (wake_index),
    .freed_valid_o(freed_valid),
    .freed_tag_o  (freed_tag),
    .count_o      (count),
    .error_o      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: live entries in program order, plus absolute head slot.
  logic [5:0] mtag[$];
  bit         mdone[$];
  int         m_head;
  bit         m_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mtag.delete();
    mdone.delete();
    m_head = 0;
    m_err  = 1'b0;
  endtask

  function automatic void model_freed(output logic [1:0] fv, output logic [11:0] ft);
    fv = '0;
    ft = '0;
    for (int k = 0; k < 2; k++) begin
      if (k < mdone.size() && mdone[k] && (k == 0 || fv[0])) begin
        fv[k] = 1'b1;
        ft[k*6 +: 6] = mtag[k];
      end
    end
  endfunction

  task automatic model_edge(input bit ev, input logic [5:0] tg, input logic [1:0] wv,
                            input logic [5:0] w0, input logic [5:0] w1);
    int sz = mdone.size();
    int n  = 0;
    int pos[2];
    bit mark[2];
    int wi[2];
    wi[0] = int'(w0);
    wi[1] = int'(w1);
    while (n < 2 && n < sz && mdone[n]) n++;
    if (ev && sz == D) m_err = 1'b1;
    for (int c = 0; c < 2; c++) begin
      mark[c] = 1'b0;
      pos[c]  = 0;
      if (wv[c]) begin
        pos[c] = (wi[c] - m_head + D) % D;
        if (pos[c] < sz && !mdone[pos[c]] && !(c == 1 && wv[0] && wi[0] == wi[1]))
          mark[c] = 1'b1;
        else
          m_err = 1'b1;
      end
    end
    for (int c = 0; c < 2; c++) if (mark[c]) mdone[pos[c]] = 1'b1;
    for (int k = 0; k < n; k++) begin
      void'(mtag.pop_front());
      void'(mdone.pop_front());
    end
    m_head = (m_head + n) % D;
    if (ev && sz < D) begin
      mtag.push_back(tg);
      mdone.push_back(1'b0);
    end
  endtask

  task automatic check_model();
    logic [1:0]  efv;
    logic [11:0] eft;
    int sz = mdone.size();
    model_freed(efv, eft);
    chk("count",       32'(count),       32'(sz));
    chk("enq_ready",   32'(enq_ready),   32'(sz != D));
    chk("enq_index",   32'(enq_index),   32'((m_head + sz) % D));
    chk("freed_valid", 32'(freed_valid), 32'(efv));
    chk("freed_tag",   32'(freed_tag),   32'(eft));
    chk("error",       32'(error),       32'(m_err));
  endtask

  // Called at a negedge: drive, take one edge, update model, check at next negedge.
  task automatic step(input bit ev, input logic [5:0] tg, input logic [1:0] wv,
                      input logic [5:0] w0, input logic [5:0] w1);
    enq_valid   = ev;
    enq_old_tag = tg;
    wake_valid  = wv;
    wake_index  = {w1, w0};
    @(posedge clk);
    model_edge(ev, tg, wv, w0, w1);
    @(negedge clk);
    enq_valid  = 1'b0;
    wake_valid = '0;
    check_model();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    enq_valid  = 1'b0;
    wake_valid = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_model();
  endtask

  typedef struct {
    bit         ev;
    logic [5:0] tg;
    logic [1:0] wv;
    logic [5:0] w0;
    logic [5:0] w1;
    int         cnt;
    logic [1:0] fv;
    logic [5:0] ft0;
    logic [5:0] ft1;
    bit         er;
  } vec_t;

  vec_t tbl[18];

  initial begin
    int cand[$];
    int i0;
    bit ev;
    logic [1:0] wv;
    logic [5:0] w0, w1;
    logic [5:0] prev_idx;
    bit wrapped;

    rst = 1'b1; enq_valid = 1'b0; enq_old_tag = '0; wake_valid = '0; wake_index = '0;
    model_reset();

    // Expected values after each row's clock edge.
    tbl[0]  = '{1, 5, 2'b00, 0, 0, 1, 2'b00, 0, 0, 0};
    tbl[1]  = '{1, 6, 2'b00, 0, 0, 2, 2'b00, 0, 0, 0};
    tbl[2]  = '{1, 7, 2'b00, 0, 0, 3, 2'b00, 0, 0, 0};
    tbl[3]  = '{0, 0, 2'b01, 1, 0, 3, 2'b00, 0, 0, 0};
    tbl[4]  = '{0, 0, 2'b01, 0, 0, 3, 2'b11, 5, 6, 0};
    tbl[5]  = '{0, 0, 2'b00, 0, 0, 1, 2'b00, 0, 0, 0};
    tbl[6]  = '{0, 0, 2'b10, 0, 2, 1, 2'b01, 7, 0, 0};
    tbl[7]  = '{0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0};
    tbl[8]  = '{1, 0, 2'b00, 0, 0, 1, 2'b00, 0, 0, 0};
    tbl[9]  = '{0, 0, 2'b01, 3, 0, 1, 2'b01, 0, 0, 0};
    tbl[10] = '{0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0};
    tbl[11] = '{1, 1, 2'b00, 0, 0, 1, 2'b00, 0, 0, 0};
    tbl[12] = '{1, 2, 2'b00, 0, 0, 2, 2'b00, 0, 0, 0};
    tbl[13] = '{1, 3, 2'b00, 0, 0, 3, 2'b00, 0, 0, 0};
    tbl[14] = '{1, 4, 2'b00, 0, 0, 4, 2'b00, 0, 0, 0};
    tbl[15] = '{0, 0, 2'b11, 4, 5, 4, 2'b11, 1, 2, 0};
    tbl[16] = '{0, 0, 2'b11, 6, 7, 2, 2'b11, 3, 4, 0};
    tbl[17] = '{0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0};

    // Reset state and directed vectors (in-order retire, tag 0, two lanes per cycle).
    do_reset();
    chk("reset_ready", 32'(enq_ready), 32'd1);
    chk("reset_index", 32'(enq_index), 32'd0);
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].ev, tbl[i].tg, tbl[i].wv, tbl[i].w0, tbl[i].w1);
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("vec%0d_fv", i),    32'(freed_valid), 32'(tbl[i].fv));
      chk($sformatf("vec%0d_ft", i),    32'(freed_tag), 32'({tbl[i].ft1, tbl[i].ft0}));
      chk($sformatf("vec%0d_err", i),   32'(error), 32'(tbl[i].er));
    end

    // Fill to DEPTH, overflow attempt, then full-with-retire timing of enq_ready.
    do_reset();
    for (int i = 0; i < D; i++) step(1, 6'(i), 2'b00, 0, 0);
    chk("full_count", 32'(count), 32'd64);
    chk("full_ready", 32'(enq_ready), 32'd0);
    step(1, 6'd9, 2'b00, 0, 0);
    chk("overflow_err", 32'(error), 32'd1);
    chk("overflow_count", 32'(count), 32'd64);
    step(0, 0, 2'b01, 0, 0);
    chk("full_retiring_fv", 32'(freed_valid[0]), 32'd1);
    chk("full_retiring_ready", 32'(enq_ready), 32'd0);
    step(0, 0, 2'b00, 0, 0);
    chk("after_retire_count", 32'(count), 32'd63);
    chk("after_retire_ready", 32'(enq_ready), 32'd1);

    // Protocol errors: duplicate channel, out-of-window, wake of slot being enqueued.
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 6'(i + 10), 2'b00, 0, 0);
    step(0, 0, 2'b11, 3, 3);
    chk("dup_wake_err", 32'(error), 32'd1);
    do_reset();
    step(1, 6'd1, 2'b00, 0, 0);
    step(1, 6'd2, 2'b00, 0, 0);
    step(0, 0, 2'b01, 5, 0);
    chk("oow_wake_err", 32'(error), 32'd1);
    chk("oow_wake_count", 32'(count), 32'd2);
    do_reset();
    step(1, 6'd3, 2'b01, 0, 0);
    chk("enq_slot_wake_err", 32'(error), 32'd1);
    chk("enq_slot_wake_fv", 32'(freed_valid), 32'd0);

    // Randomized traffic with wrap of the ring.
    do_reset();
    wrapped  = 1'b0;
    prev_idx = enq_index;
    for (int cyc = 0; cyc < 400; cyc++) begin
      ev = ($urandom_range(0, 2) != 0) && (mdone.size() < D);
      cand.delete();
      for (int p = 0; p < mdone.size(); p++) if (!mdone[p]) cand.push_back(p);
      wv = '0; w0 = '0; w1 = '0;
      if (cand.size() > 0 && $urandom_range(0, 3) != 0) begin
        i0 = $urandom_range(0, cand.size() - 1);
        w0 = 6'((m_head + cand[i0]) % D);
        wv[0] = 1'b1;
        cand.delete(i0);
      end
      if (cand.size() > 0 && $urandom_range(0, 3) != 0) begin
        i0 = $urandom_range(0, cand.size() - 1);
        w1 = 6'((m_head + cand[i0]) % D);
        wv[1] = 1'b1;
      end
      step(ev, 6'($urandom), wv, w0, w1);
      if (prev_idx == 6'd63 && enq_index == 6'd0) wrapped = 1'b1;
      prev_idx = enq_index;
    end
    chk("enq_index_wrapped", 32'(wrapped), 32'd1);

    // Asynchronous reset mid-stream with pending retirement and a latched error.
    do_reset();
    for (int i = 0; i < 10; i++) step(1, 6'(i + 20), 2'b00, 0, 0);
    step(0, 0, 2'b11, 0, 40);
    chk("pre_rst_count", 32'(count), 32'd10);
    chk("pre_rst_fv", 32'(freed_valid), 32'd1);
    chk("pre_rst_err", 32'(error), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_fv", 32'(freed_valid), 32'd0);
    chk("async_rst_ft", 32'(freed_tag), 32'd0);
    chk("async_rst_err", 32'(error), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_model();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
`default_nettype wire
